// File: rtl/soc_top_if.sv
// Board-side signal bundle for soc_top: push buttons and switches in,
// RGB state LEDs, echo LEDs and 7-segment display value out.
interface soc_top_if;
  logic        start_asin;
  logic        resume_asin;
  logic [15:0] in;
  logic [5:0]  color_leds;
  logic [15:0] leds;
  logic [15:0] display;

  modport master (
    output start_asin, resume_asin, in,
    input  color_leds, leds, display
  );

  modport slave (
    input  start_asin, resume_asin, in,
    output color_leds, leds, display
  );
endinterface

// File: rtl/soc_top.sv
// Demo SoC top: Fibonacci print sequencer driven by start/resume buttons.
// Define SOC_TOP_DEBOUNCE_EN to insert the button debouncers.
module soc_top #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int DEFAULT_TERMS   = 10
) (
  input  logic       clk,
  input  logic       rst_asin,
  soc_top_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, PRINT, DONE} state_t;

  localparam logic [5:0] COL_IDLE  = 6'b001_001;
  localparam logic [5:0] COL_RUN   = 6'b100_100;
  localparam logic [5:0] COL_PRINT = 6'b101_101;
  localparam logic [5:0] COL_DONE  = 6'b010_010;

  // Reset asserts immediately but releases only on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge rst_asin) begin
    if (!rst_asin) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // Bit 0 is start, bit 1 is resume throughout the button path.
  logic [1:0] sync0, sync1, level, level_prev, pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= 2'b00;
      sync1 <= 2'b00;
    end else begin
      sync0 <= {bus.resume_asin, bus.start_asin};
      sync1 <= sync0;
    end
  end

`ifdef SOC_TOP_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] deb_cnt [2];

  // A new level is accepted only after it has differed from the current one for the full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 2'b00;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync1[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] >= CNT_LAST) begin
          level[i]   <= sync1[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign level = sync1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev <= 2'b00;
      pulse      <= 2'b00;
    end else begin
      level_prev <= level;
      pulse      <= level & ~level_prev;
    end
  end

  state_t      state;
  logic [5:0]  color_q;
  logic [31:0] value, fib_a, fib_b;
  logic [4:0]  term_k, term_n;

  // Sequencer: RUN computes one term, PRINT holds it until the user resumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      color_q <= COL_IDLE;
      value   <= '0;
      fib_a   <= '0;
      fib_b   <= 32'd1;
      term_k  <= '0;
      term_n  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (pulse[0]) begin
            term_n  <= (bus.in[4:0] == 5'd0) ? 5'(DEFAULT_TERMS) : bus.in[4:0];
            fib_a   <= '0;
            fib_b   <= 32'd1;
            term_k  <= '0;
            state   <= RUN;
            color_q <= COL_RUN;
          end
        end
        RUN: begin
          value   <= fib_a;
          fib_a   <= fib_b;
          fib_b   <= fib_a + fib_b;
          term_k  <= term_k + 5'd1;
          state   <= PRINT;
          color_q <= COL_PRINT;
        end
        PRINT: begin
          if (pulse[1]) begin
            if (term_k < term_n) begin
              state   <= RUN;
              color_q <= COL_RUN;
            end else begin
              state   <= DONE;
              color_q <= COL_DONE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          color_q <= COL_IDLE;
        end
      endcase
    end
  end

  assign bus.color_leds = color_q;
  assign bus.display    = value[15:0];
  assign bus.leds       = (state == IDLE) ? bus.in : value[31:16];

endmodule

// File: tb/tb_soc_top.sv
// Self-checking bench for soc_top: table of program runs, hand-written
// corner sequences, and randomized runs against a Fibonacci reference.
module tb_soc_top;

  localparam int DEB     = 8;
  localparam int REL     = 20;
  localparam int BUDGET  = 200;

  localparam logic [5:0] COL_IDLE  = 6'b001_001;
  localparam logic [5:0] COL_PRINT = 6'b101_101;
  localparam logic [5:0] COL_DONE  = 6'b010_010;

  logic clk = 1'b0;
  logic rst_asin;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  soc_top_if bus ();

  soc_top #(.DEBOUNCE_CYCLES(DEB), .DEFAULT_TERMS(10)) dut (
    .clk      (clk),
    .rst_asin (rst_asin),
    .bus      (bus)
  );

  typedef struct {
    logic [15:0] sw;
    int          hold;
    int          exp_terms;
    logic [31:0] exp_last;
  } vec_t;

  // Reference: n-th Fibonacci number with 32-bit wrap, F(0)=0.
  function automatic logic [31:0] fib(input int n);
    logic [31:0] x, y, t;
    x = 32'd0;
    y = 32'd1;
    for (int i = 0; i < n; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Press one button for hold cycles, then release and let the release settle.
  task automatic applyStimulus(input bit is_resume, input int hold);
    @(negedge clk);
    if (is_resume) bus.resume_asin = 1'b1;
    else           bus.start_asin  = 1'b1;
    repeat (hold) @(negedge clk);
    bus.resume_asin = 1'b0;
    bus.start_asin  = 1'b0;
    repeat (REL) @(negedge clk);
  endtask

  task automatic waitColor(input string name, input logic [5:0] col);
    int n;
    n = 0;
    while (bus.color_leds !== col && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {26'd0, bus.color_leds}, {26'd0, col});
  endtask

  task automatic doReset(input logic [15:0] sw);
    @(negedge clk);
    bus.in      = sw;
    rst_asin    = 1'b0;
    repeat (4) @(negedge clk);
    rst_asin    = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Run a whole program from IDLE or DONE, checking every print against fib().
  task automatic runProgram(input logic [15:0] sw, input int hold,
                            output int printed, output logic [31:0] last_val);
    int n_terms;
    n_terms  = (sw[4:0] == 5'd0) ? 10 : int'(sw[4:0]);
    printed  = 0;
    bus.in   = sw;
    applyStimulus(1'b0, hold);
    for (int i = 0; i < n_terms; i++) begin
      waitColor("print_state", COL_PRINT);
      checkOutput("print_value", {bus.leds, bus.display}, fib(i));
      printed++;
      applyStimulus(1'b1, hold);
    end
    waitColor("done_state", COL_DONE);
    last_val = {bus.leds, bus.display};
  endtask

  initial begin
    vec_t        vecs [5];
    int          printed;
    logic [31:0] last_val;
    logic [15:0] rsw;

    vecs[0] = '{sw: 16'h0000, hold: 20, exp_terms: 10, exp_last: 32'd34};
    vecs[1] = '{sw: 16'h0003, hold: 20, exp_terms: 3,  exp_last: 32'd1};
    vecs[2] = '{sw: 16'hFFE1, hold: 60, exp_terms: 1,  exp_last: 32'd0};
    vecs[3] = '{sw: 16'h0007, hold: 20, exp_terms: 7,  exp_last: 32'd8};
    vecs[4] = '{sw: 16'h001F, hold: 20, exp_terms: 31, exp_last: 32'd832040};

    bus.start_asin  = 1'b0;
    bus.resume_asin = 1'b0;
    bus.in          = 16'h00A5;
    rst_asin        = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_color", {26'd0, bus.color_leds}, {26'd0, COL_IDLE});
    checkOutput("reset_display", {16'd0, bus.display}, 32'd0);
    checkOutput("reset_leds", {16'd0, bus.leds}, 32'h00A5);
    rst_asin = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("idle_hold_color", {26'd0, bus.color_leds}, {26'd0, COL_IDLE});
    checkOutput("idle_leds_echo", {16'd0, bus.leds}, 32'h00A5);

    applyStimulus(1'b1, 20);
    checkOutput("resume_in_idle", {26'd0, bus.color_leds}, {26'd0, COL_IDLE});

    foreach (vecs[v]) begin
      runProgram(vecs[v].sw, vecs[v].hold, printed, last_val);
      checkOutput("vec_terms", printed, vecs[v].exp_terms);
      checkOutput("vec_last", last_val, vecs[v].exp_last);
      checkOutput("vec_last_model", last_val, fib(vecs[v].exp_terms - 1));
    end

    applyStimulus(1'b1, 20);
    checkOutput("resume_in_done", {26'd0, bus.color_leds}, {26'd0, COL_DONE});
    checkOutput("done_holds_value", {bus.leds, bus.display}, fib(30));

    // From DONE: new run, ignored start in PRINT, then reset during the 4th print.
    bus.in = 16'h0005;
    applyStimulus(1'b0, 20);
    waitColor("restart_print", COL_PRINT);
    checkOutput("restart_first", {bus.leds, bus.display}, 32'd0);
    applyStimulus(1'b0, 20);
    checkOutput("start_in_print", {26'd0, bus.color_leds}, {26'd0, COL_PRINT});
    checkOutput("start_in_print_val", {bus.leds, bus.display}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b1, 20);
      waitColor("mid_print", COL_PRINT);
      checkOutput("mid_value", {bus.leds, bus.display}, fib(i));
    end
    #2 rst_asin = 1'b0;
    #1;
    checkOutput("async_rst_color", {26'd0, bus.color_leds}, {26'd0, COL_IDLE});
    checkOutput("async_rst_display", {16'd0, bus.display}, 32'd0);
    checkOutput("async_rst_leds", {16'd0, bus.leds}, 32'h0005);
    repeat (5) @(negedge clk);
    rst_asin = 1'b1;
    repeat (5) @(negedge clk);
    applyStimulus(1'b0, 20);
    waitColor("post_rst_print", COL_PRINT);
    checkOutput("post_rst_first", {bus.leds, bus.display}, 32'd0);

`ifdef SOC_TOP_DEBOUNCE_EN
    applyStimulus(1'b1, DEB - 5);
    repeat (30) @(negedge clk);
    checkOutput("glitch_color", {26'd0, bus.color_leds}, {26'd0, COL_PRINT});
    checkOutput("glitch_value", {bus.leds, bus.display}, 32'd0);
`endif

    for (int r = 0; r < 4; r++) begin
      rsw = 16'($urandom);
      doReset(rsw);
      checkOutput("rand_idle_leds", {16'd0, bus.leds}, {16'd0, rsw});
      runProgram(rsw, int'($urandom_range(DEB + 4, 40)), printed, last_val);
      checkOutput("rand_terms", printed, (rsw[4:0] == 5'd0) ? 10 : int'(rsw[4:0]));
      checkOutput("rand_last", last_val, fib(printed - 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
